im_loader: RTL

Loadable instruction memory for the single-cycle CPU. After reset it accepts a program as a big-endian byte stream over a valid/ready handshake and packs it into 32-bit words. It holds the CPU in reset while loading. Once the last byte arrives, it releases the CPU and serves instruction fetches combinationally from `pc`. It is the write side of the instruction-memory interface the CPU reads from.

---
 rtl/im_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/im_loader.sv
// Loadable instruction memory: packs a big-endian byte stream into 32-bit words,
// holds the CPU in reset while loading, then serves fetches combinationally from pc.
module im_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   // Handshake: a byte moves on a rising edge where in_valid and in_ready are both high;
   // in_ready depends only on state, never on in_valid, and in_last counts only with in_valid.
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic [31:0]           pc,
   output logic [31:0]           instruction,
   output logic                  cpu_reset,
   output logic                  load_done,
   output logic [ADDR_WIDTH:0]   word_count,
   output logic                  err_overflow,
   output logic                  debug_state
);

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t                state;
   logic [1:0]            byte_cnt;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [31:0]           asm_word;
   logic [31:0]           mem [DEPTH];

   logic                  xfer;
   logic                  full;
   logic                  wr_en;
   logic [31:0]           wr_data;
   logic [ADDR_WIDTH-1:0] fetch_idx;
   logic                  unused_pc;

   assign debug_state = state;
   assign xfer        = in_valid & in_ready;
   assign full        = word_count[ADDR_WIDTH];
   assign fetch_idx   = pc[ADDR_WIDTH+1:2];
   assign unused_pc   = ^{pc[31:ADDR_WIDTH+2], pc[1:0]};

   // A word is written on its 4th byte, or early on in_last with the partial
   // word left-justified and zero-padded. Nothing is written once memory is full.
   always_comb begin
      wr_en   = 1'b0;
      wr_data = 32'h0;
      case (byte_cnt)
         2'd0:    wr_data = {in_data, 24'h0};
         2'd1:    wr_data = {asm_word[7:0], in_data, 16'h0};
         2'd2:    wr_data = {asm_word[15:0], in_data, 8'h0};
         default: wr_data = {asm_word[23:0], in_data};
      endcase
      if (xfer && !full && (byte_cnt == 2'd3 || in_last))
         wr_en = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= LOAD;
         byte_cnt     <= 2'd0;
         wr_addr      <= '0;
         word_count   <= '0;
         asm_word     <= 32'h0;
         err_overflow <= 1'b0;
         in_ready     <= 1'b1;
         cpu_reset    <= 1'b1;
         load_done    <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (xfer) begin
                  asm_word <= {asm_word[23:0], in_data};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (full)
                     err_overflow <= 1'b1;
                  if (wr_en) begin
                     word_count <= word_count + 1'b1;
                     wr_addr    <= wr_addr + 1'b1;
                  end
                  if (in_last) begin
                     state     <= RUN;
                     in_ready  <= 1'b0;
                     cpu_reset <= 1'b0;
                     load_done <= 1'b1;
                  end
               end
            end
            RUN: begin
               state <= RUN;
            end
            default: begin
               state <= LOAD;
            end
         endcase
      end
   end

   // Storage is not reset; stale words stay hidden behind word_count.
   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_comb begin
      instruction = 32'h0;
      if (state == RUN && {1'b0, fetch_idx} < word_count)
         instruction = mem[fetch_idx];
   end

endmodule
